// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage constants, exception codes and IF/ID action type
package fetch_unit_pkg;

    // Default fetch addresses
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

    // Exception codes carried down the pipe
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_RI   = 5'd10;

    // Instruction memory bounds (inclusive)
    localparam logic [31:0] IMEM_LO = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI = 32'h0000_6FFF;

    // What the IF/ID register does on the next edge
    typedef enum logic [1:0] {
        IFID_LOAD  = 2'd0,
        IFID_HOLD  = 2'd1,
        IFID_CLEAR = 2'd2
    } ifid_act_e;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - combinational next-PC mux and fetch address checks
// Macro: FETCH_RANGE_CHECK_EN adds an instruction-memory bounds check to AdEL.
// Ports:
//   f_pc_i      current fetch PC
//   exc_req_i   exception/interrupt request (highest priority)
//   stall_i     hold the PC
//   npc_valid_i decode redirect valid
//   npc_i       redirect target
//   next_pc_o   PC to load on the next edge
//   adel_o      current fetch address raises AdEL
module fetch_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic [31:0] f_pc_i,
    input  logic        exc_req_i,
    input  logic        stall_i,
    input  logic        npc_valid_i,
    input  logic [31:0] npc_i,
    output logic [31:0] next_pc_o,
    output logic        adel_o
);

    always_comb begin
        next_pc_o = f_pc_i + 32'd4;  // wraps modulo 2^32
        if (exc_req_i) begin
            next_pc_o = HANDLER_PC;
        end else if (stall_i) begin
            // A redirect during a stall is dropped; decode re-presents it.
            next_pc_o = f_pc_i;
        end else if (npc_valid_i) begin
            next_pc_o = npc_i;
        end
    end

`ifdef FETCH_RANGE_CHECK_EN
    assign adel_o = pc_misaligned(f_pc_i) || (f_pc_i < IMEM_LO) || (f_pc_i > IMEM_HI);
`else
    assign adel_o = pc_misaligned(f_pc_i);
`endif

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register and IF/ID register
// Macro: FETCH_RANGE_CHECK_EN (passed through to fetch_pc_gen) enables the bounds check.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stall                 hazard hold from decode
//   npc_valid, npc        decode redirect and its target
//   d_is_ctrl, d_is_eret  instruction in D is a branch/jump, or eret
//   exc_req               exception/interrupt flush
//   i_addr, i_rdata       instruction memory address / combinational read data
//   d_pc, d_instr, d_exccode, d_bd   IF/ID register outputs
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    input  logic        d_is_ctrl,
    input  logic        d_is_eret,
    input  logic        exc_req,
    output logic [31:0] i_addr,
    input  logic [31:0] i_rdata,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [4:0]  d_exccode,
    output logic        d_bd
);

    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [4:0]  d_exccode_q, d_exccode_d;
    logic        d_bd_q, d_bd_d;
    logic        adel;
    ifid_act_e   ifid_act;

    fetch_pc_gen #(
        .HANDLER_PC (HANDLER_PC)
    ) u_pc_gen (
        .f_pc_i      (f_pc_q),
        .exc_req_i   (exc_req),
        .stall_i     (stall),
        .npc_valid_i (npc_valid),
        .npc_i       (npc),
        .next_pc_o   (f_pc_d),
        .adel_o      (adel)
    );

    // eret has no delay slot, so whatever was fetched behind it is squashed.
    always_comb begin
        ifid_act = IFID_LOAD;
        if (exc_req) begin
            ifid_act = IFID_CLEAR;
        end else if (stall) begin
            ifid_act = IFID_HOLD;
        end else if (d_is_eret) begin
            ifid_act = IFID_CLEAR;
        end
    end

    always_comb begin
        d_pc_d      = d_pc_q;
        d_instr_d   = d_instr_q;
        d_exccode_d = d_exccode_q;
        d_bd_d      = d_bd_q;
        case (ifid_act)
            IFID_LOAD: begin
                // A faulting fetch keeps its PC for EPC but carries no instruction.
                d_pc_d      = f_pc_q;
                d_instr_d   = adel ? 32'd0 : i_rdata;
                d_exccode_d = adel ? EXC_ADEL : 5'd0;
                d_bd_d      = d_is_ctrl;
            end
            IFID_CLEAR: begin
                d_pc_d      = 32'd0;
                d_instr_d   = 32'd0;
                d_exccode_d = 5'd0;
                d_bd_d      = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q      <= RESET_PC;
            d_pc_q      <= 32'd0;
            d_instr_q   <= 32'd0;
            d_exccode_q <= 5'd0;
            d_bd_q      <= 1'b0;
        end else begin
            f_pc_q      <= f_pc_d;
            d_pc_q      <= d_pc_d;
            d_instr_q   <= d_instr_d;
            d_exccode_q <= d_exccode_d;
            d_bd_q      <= d_bd_d;
        end
    end

    assign i_addr    = f_pc_q;
    assign d_pc      = d_pc_q;
    assign d_instr   = d_instr_q;
    assign d_exccode = d_exccode_q;
    assign d_bd      = d_bd_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, npc_valid, d_is_ctrl, d_is_eret, exc_req;
    logic [31:0] npc, i_addr, i_rdata, d_pc, d_instr;
    logic [4:0]  d_exccode;
    logic        d_bd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_valid (npc_valid),
        .npc       (npc),
        .d_is_ctrl (d_is_ctrl),
        .d_is_eret (d_is_eret),
        .exc_req   (exc_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .d_pc      (d_pc),
        .d_instr   (d_instr),
        .d_exccode (d_exccode),
        .d_bd      (d_bd)
    );

    typedef struct {
        logic        stall;
        logic        nv;
        logic [31:0] npc;
        logic        ctrl;
        logic        eret;
        logic        exc;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [4:0]  e_exc;
        logic        e_bd;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic [4:0] e_exc, input logic e_bd);
        check({tag, ".i_addr"},    i_addr, e_addr);
        check({tag, ".d_pc"},      d_pc, e_pc);
        check({tag, ".d_instr"},   d_instr, e_instr);
        check({tag, ".d_exccode"}, {27'd0, d_exccode}, {27'd0, e_exc});
        check({tag, ".d_bd"},      {31'd0, d_bd}, {31'd0, e_bd});
    endtask

    task automatic idle_inputs();
        stall = 0; npc_valid = 0; npc = 32'd0; d_is_ctrl = 0;
        d_is_eret = 0; exc_req = 0; i_rdata = 32'd0;
    endtask

    initial begin
        //            stall nv npc           ctrl eret exc rdata         | i_addr        d_pc          d_instr       exc  bd
        vecs[0]  = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_0000, 32'h0000_3004, 32'h0000_3000, 32'hA000_0000, 5'd0, 0};
        vecs[1]  = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_0001, 32'h0000_3008, 32'h0000_3004, 32'hA000_0001, 5'd0, 0};
        vecs[2]  = '{0, 1, 32'h0000_3100, 1, 0, 0, 32'hA000_0002, 32'h0000_3100, 32'h0000_3008, 32'hA000_0002, 5'd0, 1};
        vecs[3]  = '{1, 1, 32'h0000_3200, 0, 0, 0, 32'hA000_0003, 32'h0000_3100, 32'h0000_3008, 32'hA000_0002, 5'd0, 1};
        vecs[4]  = '{1, 1, 32'h0000_3200, 0, 0, 0, 32'hA000_0003, 32'h0000_3100, 32'h0000_3008, 32'hA000_0002, 5'd0, 1};
        vecs[5]  = '{1, 1, 32'h0000_3200, 0, 0, 0, 32'hA000_0003, 32'h0000_3100, 32'h0000_3008, 32'hA000_0002, 5'd0, 1};
        vecs[6]  = '{0, 1, 32'h0000_3200, 0, 0, 0, 32'hA000_0003, 32'h0000_3200, 32'h0000_3100, 32'hA000_0003, 5'd0, 0};
        vecs[7]  = '{1, 0, 32'h0,         0, 0, 1, 32'hA000_0004, 32'h0000_4180, 32'h0,         32'h0,         5'd0, 0};
        vecs[8]  = '{0, 1, 32'h0000_3101, 1, 0, 0, 32'hA000_0005, 32'h0000_3101, 32'h0000_4180, 32'hA000_0005, 5'd0, 1};
        vecs[9]  = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_0006, 32'h0000_3105, 32'h0000_3101, 32'h0,         5'd4, 0};
        vecs[10] = '{0, 1, 32'h0000_3040, 0, 1, 0, 32'hA000_0007, 32'h0000_3040, 32'h0,         32'h0,         5'd0, 0};
        vecs[11] = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_0008, 32'h0000_3044, 32'h0000_3040, 32'hA000_0008, 5'd0, 0};
        vecs[12] = '{0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hA000_0009, 32'hFFFF_FFFC, 32'h0000_3044, 32'hA000_0009, 5'd0, 0};
`ifdef FETCH_RANGE_CHECK_EN
        vecs[13] = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_000A, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,         5'd4, 0};
        vecs[14] = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_000B, 32'h0000_0004, 32'h0000_0000, 32'h0,         5'd4, 0};
`else
        vecs[13] = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_000A, 32'h0000_0000, 32'hFFFF_FFFC, 32'hA000_000A, 5'd0, 0};
        vecs[14] = '{0, 0, 32'h0,         0, 0, 0, 32'hA000_000B, 32'h0000_0004, 32'h0000_0000, 32'hA000_000B, 5'd0, 0};
`endif

        idle_inputs();
        reset = 1'b1;
        #2;
        check_d("reset", 32'h0000_3000, 32'h0, 32'h0, 5'd0, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            stall     = vecs[i].stall;
            npc_valid = vecs[i].nv;
            npc       = vecs[i].npc;
            d_is_ctrl = vecs[i].ctrl;
            d_is_eret = vecs[i].eret;
            exc_req   = vecs[i].exc;
            i_rdata   = vecs[i].rdata;
            @(posedge clk);
            #1;
            check_d($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc,
                    vecs[i].e_instr, vecs[i].e_exc, vecs[i].e_bd);
            @(negedge clk);
        end

        // Reset pulsed in the middle of a stall with a pending redirect
        stall = 1; npc_valid = 1; npc = 32'h0000_3300; i_rdata = 32'hB000_0000;
        @(posedge clk);
        #1;
        check("pre_rst.i_addr", i_addr, 32'h0000_0004);
        #2;
        reset = 1'b1;
        #1;
        check_d("mid_rst", 32'h0000_3000, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        i_rdata = 32'hB000_0001;
        @(posedge clk);
        #1;
        check_d("post_rst", 32'h0000_3004, 32'h0000_3000, 32'hB000_0001, 5'd0, 1'b0);

`ifdef FETCH_RANGE_CHECK_EN
        @(negedge clk);
        npc_valid = 1; npc = 32'h0000_8000; i_rdata = 32'hB000_0002;
        @(posedge clk);
        #1;
        check("rng_redir.i_addr", i_addr, 32'h0000_8000);
        @(negedge clk);
        idle_inputs();
        i_rdata = 32'hB000_0003;
        @(posedge clk);
        #1;
        check_d("rng_8000", 32'h0000_8004, 32'h0000_8000, 32'h0, 5'd4, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, the exception/interrupt entry address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard hold from the decode stage.
REQ-006 SHALL have port npc_valid  input  1  decode stage redirect (branch taken, jump, eret).
REQ-007 SHALL have port npc  input  32  redirect target computed by decode.
REQ-008 SHALL have port d_is_ctrl  input  1  the instruction in D is a branch or jump, taken or not.
REQ-009 SHALL have port d_is_eret  input  1  the instruction in D is eret.
REQ-010 SHALL have port exc_req  input  1  CP0 exception/interrupt request, flushes the pipe.
REQ-011 SHALL have port i_addr  output  32  instruction memory address, equal to f_pc.
REQ-012 SHALL have port i_rdata  input  32  combinational instruction memory read data.
REQ-013 SHALL have ports d_pc/d_instr (output, 32 each), d_exccode (output, 5) and d_bd (output, 1) forming the IF/ID register.

Function
REQ-014 SHALL hold internal register f_pc; i_addr = f_pc combinationally.
REQ-015 SHALL select next f_pc with priority: exc_req -> HANDLER_PC; stall -> hold; npc_valid -> npc; else f_pc+4, wrapping modulo 2^32.
REQ-016 SHALL update the IF/ID register with priority: exc_req -> clear; stall -> hold; d_is_eret -> clear (eret has no delay slot); else load the fetched instruction.
REQ-017 Clear SHALL mean d_pc=0, d_instr=0, d_exccode=0, d_bd=0.
REQ-018 Load SHALL mean d_pc=f_pc, d_instr=i_rdata, d_exccode=0, d_bd=d_is_ctrl.
REQ-019 SHALL raise AdEL when f_pc[1:0]!=0, loading d_exccode=5'd4 and d_instr=0 while keeping d_pc=f_pc.
REQ-020 When AdEL is raised, SHALL still set d_bd as in REQ-018; f_pc SHALL still advance per REQ-015.
REQ-021 SHALL have a latency of exactly one cycle from a fetch at f_pc to that instruction appearing at the D outputs.
REQ-022 When exc_req and stall are both high, exc_req SHALL win.
REQ-023 When stall and npc_valid are both high, the redirect SHALL be ignored; decode re-presents it after the stall.
REQ-024 When d_is_eret and npc_valid are both high without stall, f_pc SHALL become npc (the EPC) and IF/ID SHALL clear.

Reset
REQ-025 On reset assertion, SHALL immediately, without a clock, set f_pc=RESET_PC and clear IF/ID per REQ-017.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; the first post-reset fetch SHALL be RESET_PC.

Configuration
REQ-027 With FETCH_RANGE_CHECK_EN defined, SHALL also raise AdEL (code 4) when f_pc is outside [32'h0000_3000, 32'h0000_6FFF].
REQ-028 Without FETCH_RANGE_CHECK_EN, SHALL check only alignment (REQ-019), and all addresses SHALL be fetchable.

Structure
REQ-029 RESET_PC/HANDLER_PC defaults, the exception codes (AdEL=4, RI=10) and the instruction-memory bounds SHALL live in the shared macro header used by all pipeline stages.
REQ-030 SHALL use one sub-module, fetch_pc_gen: a combinational next-PC mux plus the alignment/range checks; fetch_unit owns both registers.

Verification
REQ-031 Reset release, no stalls -> i_addr 0x3000, 0x3004, 0x3008; d_pc follows one cycle later with d_exccode=0.
REQ-032 d_is_ctrl=1 and npc_valid=1 with npc=0x3100 while f_pc=0x3008 -> d_pc=0x3008 with d_bd=1; the next fetch is 0x3100.
REQ-033 stall=1 for 3 cycles with npc_valid=1 -> f_pc and all D outputs are unchanged; after release, the fetch continues at the redirect target.
REQ-034 exc_req=1 together with stall=1 -> next f_pc=0x4180 and IF/ID cleared (d_instr=0, d_pc=0).
REQ-035 npc=0x3101 taken -> the following cycle gives d_pc=0x3101, d_exccode=4, d_instr=0; with FETCH_RANGE_CHECK_EN defined, npc=0x8000 also gives code 4.
REQ-036 d_is_eret=1, npc_valid=1, npc=0x3040 -> IF/ID cleared and the next fetch is 0x3040; reset pulsed mid-stall -> f_pc=0x3000 immediately.
